// File: rtl/ls_issue_buf.sv
// Dual-issue in-order load/store buffer: accepts up to two ordered entries (A older than B) per cycle, pops one per cycle.
// Latency: a write reaches ls_valid_o after one cycle; with LS_ISSUE_BUF_BYPASS_EN an empty buffer presents the entry in the same cycle.
// Backpressure: in_rdy_o is low unless two free slots exist, and it comes from registered state only; ls_rdy_i stalls the head entry.
module ls_issue_buf #(
   parameter int Depth = 4,
   parameter int EntW  = 128
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     a_valid_i,
   input  logic [EntW-1:0]          a_data_i,
   input  logic                     b_valid_i,
   input  logic [EntW-1:0]          b_data_i,
   output logic                     in_rdy_o,
   output logic                     ls_valid_o,
   output logic [EntW-1:0]          ls_data_o,
   input  logic                     ls_rdy_i,
   output logic [$clog2(Depth):0]   count_o,
   output logic                     empty_o
);

   localparam int PtrW = $clog2(Depth);
   localparam int CntW = PtrW + 1;
   // Highest occupancy that still leaves room for a full A+B pair.
   localparam logic [CntW-1:0] PairMaxCnt = CntW'(Depth - 2);

   logic [EntW-1:0] mem [Depth];
   logic [PtrW-1:0] wr_ptr;
   logic [PtrW-1:0] rd_ptr;
   logic [PtrW-1:0] wr_ptr_p1;
   logic [CntW-1:0] count;

   logic            wr0_en;
   logic            wr1_en;
   logic [EntW-1:0] wr0_dat;
   logic [EntW-1:0] wr1_dat;
   logic [1:0]      n_wr;
   logic            pop_buf;
   logic            byp_take;

   assign count_o   = count;
   assign empty_o   = (count == '0);
   assign in_rdy_o  = (count <= PairMaxCnt);
   assign wr_ptr_p1 = wr_ptr + PtrW'(1);

`ifdef LS_ISSUE_BUF_BYPASS_EN
   // While empty the issue slots drive the LS pipeline directly; the oldest valid slot is the one presented.
   logic byp_act;
   assign byp_act    = empty_o & (a_valid_i | b_valid_i);
   assign ls_valid_o = (~empty_o | byp_act) & ~flush_i;
   assign ls_data_o  = empty_o ? (a_valid_i ? a_data_i : b_data_i) : mem[rd_ptr];
   // A bypassed entry accepted by the pipeline never occupies a slot.
   assign byp_take   = byp_act & ls_rdy_i & ~flush_i;
`else
   assign ls_valid_o = ~empty_o & ~flush_i;
   assign ls_data_o  = mem[rd_ptr];
   assign byp_take   = 1'b0;
`endif

   // Only a buffered head entry advances rd_ptr; a bypass pop leaves the buffer untouched.
   assign pop_buf = ls_valid_o & ls_rdy_i & ~empty_o;

   // Pack the accepted slots into consecutive write lanes, oldest first, skipping a bypassed A.
   always_comb begin
      wr0_en  = 1'b0;
      wr1_en  = 1'b0;
      wr0_dat = a_data_i;
      wr1_dat = b_data_i;
      if (in_rdy_o && !flush_i) begin
         if (byp_take) begin
            // Only a B queued behind a bypassed A needs storing.
            if (a_valid_i && b_valid_i) begin
               wr0_en  = 1'b1;
               wr0_dat = b_data_i;
            end
         end else if (a_valid_i && b_valid_i) begin
            wr0_en = 1'b1;
            wr1_en = 1'b1;
         end else if (a_valid_i) begin
            wr0_en = 1'b1;
         end else if (b_valid_i) begin
            wr0_en  = 1'b1;
            wr0_dat = b_data_i;
         end
      end
      n_wr = {1'b0, wr0_en} + {1'b0, wr1_en};
   end

   // Pointer and occupancy state; reset beats flush, flush beats all traffic.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PtrW'(n_wr);
         if (pop_buf) begin
            rd_ptr <= rd_ptr + PtrW'(1);
         end
         count <= count + CntW'(n_wr) - CntW'(pop_buf);
      end
   end

   // Payload storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (wr0_en) begin
            mem[wr_ptr] <= wr0_dat;
         end
         if (wr1_en) begin
            mem[wr_ptr_p1] <= wr1_dat;
         end
      end
   end

endmodule

// File: tb/tb_ls_issue_buf.sv
module tb_ls_issue_buf;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        a_valid;
   logic [15:0] a_data;
   logic        b_valid;
   logic [15:0] b_data;
   logic        in_rdy;
   logic        ls_valid;
   logic [15:0] ls_data;
   logic        ls_rdy;
   logic [2:0]  count;
   logic        empty;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ls_issue_buf #(.Depth(4), .EntW(16)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .flush_i    (flush),
      .a_valid_i  (a_valid),
      .a_data_i   (a_data),
      .b_valid_i  (b_valid),
      .b_data_i   (b_data),
      .in_rdy_o   (in_rdy),
      .ls_valid_o (ls_valid),
      .ls_data_o  (ls_data),
      .ls_rdy_i   (ls_rdy),
      .count_o    (count),
      .empty_o    (empty)
   );

   // Advance past one rising edge; inputs change and outputs are sampled 1 time unit later.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush   = 1'b0;
      a_valid = 1'b0;
      b_valid = 1'b0;
      ls_rdy  = 1'b0;
      a_data  = 16'h0;
      b_data  = 16'h0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      #1;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
      checks++; if (ls_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ls_valid); end
      checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b expected 1", in_rdy); end
   endtask

   task automatic test_single();
      a_valid = 1'b1; a_data = 16'h0011;
      #1;
      checks++; if (ls_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b expected 0", ls_valid); end
      cyc();
      a_valid = 1'b0;
      #1;
      checks++; if (ls_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", ls_valid); end
      checks++; if (ls_data !== 16'h0011) begin errors++; $display("FAIL single_data: got %h expected 0011", ls_data); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
      cyc();
      checks++; if (ls_data !== 16'h0011) begin errors++; $display("FAIL single_stall_data: got %h expected 0011", ls_data); end
      ls_rdy = 1'b1;
      cyc();
      ls_rdy = 1'b0;
      #1;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty: got %b expected 1", empty); end
      checks++; if (ls_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b expected 0", ls_valid); end
   endtask

   task automatic test_pair();
      a_valid = 1'b1; a_data = 16'h00A1;
      b_valid = 1'b1; b_data = 16'h00B2;
      ls_rdy  = 1'b1;
      cyc();
      a_valid = 1'b0; b_valid = 1'b0;
      #1;
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL pair_count: got %0d expected 2", count); end
      checks++; if (ls_data !== 16'h00A1) begin errors++; $display("FAIL pair_first: got %h expected 00a1", ls_data); end
      cyc();
      checks++; if (ls_data !== 16'h00B2) begin errors++; $display("FAIL pair_second: got %h expected 00b2", ls_data); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL pair_count_after: got %0d expected 1", count); end
      cyc();
      checks++; if (ls_valid !== 1'b0) begin errors++; $display("FAIL pair_drained: got %b expected 0", ls_valid); end
      ls_rdy = 1'b0;
   endtask

   task automatic test_full();
      ls_rdy = 1'b0;
      a_valid = 1'b1; a_data = 16'h0001;
      b_valid = 1'b1; b_data = 16'h0002;
      cyc();
      b_valid = 1'b0; a_data = 16'h0003;
      #1;
      checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_at2: got %b expected 1", in_rdy); end
      cyc();
      a_data = 16'h0099;
      #1;
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_count3: got %0d expected 3", count); end
      checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy_at3: got %b expected 0", in_rdy); end
      cyc();
      a_valid = 1'b0;
      #1;
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_ignored_write: got %0d expected 3", count); end
      checks++; if (ls_data !== 16'h0001) begin errors++; $display("FAIL full_head: got %h expected 0001", ls_data); end
      ls_rdy = 1'b1;
      cyc();
      ls_rdy = 1'b0;
      #1;
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL full_pop_count: got %0d expected 2", count); end
      checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL full_pop_rdy: got %b expected 1", in_rdy); end
      checks++; if (ls_data !== 16'h0002) begin errors++; $display("FAIL full_pop_head: got %h expected 0002", ls_data); end
   endtask

   // Continues from test_full: entries 2,3 buffered, write pointer about to wrap.
   task automatic test_wrap();
      logic [15:0] exp_q [3];
      exp_q[0] = 16'h0003; exp_q[1] = 16'h0004; exp_q[2] = 16'h0005;
      a_valid = 1'b1; a_data = 16'h0004;
      b_valid = 1'b1; b_data = 16'h0005;
      ls_rdy  = 1'b1;
      cyc();
      a_valid = 1'b0; b_valid = 1'b0;
      #1;
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL wrap_count: got %0d expected 3", count); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (ls_valid !== 1'b1 || ls_data !== exp_q[i]) begin
            errors++; $display("FAIL wrap_order[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, ls_valid, ls_data, exp_q[i]);
         end
         cyc();
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_drained: got %b expected 1", empty); end
      ls_rdy = 1'b0;
   endtask

   task automatic test_flush();
      a_valid = 1'b1; a_data = 16'h0007;
      b_valid = 1'b1; b_data = 16'h0008;
      cyc();
      b_valid = 1'b0; a_data = 16'h0009;
      cyc();
      a_data = 16'h00EE; flush = 1'b1; ls_rdy = 1'b1;
      #1;
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
      checks++; if (ls_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle_valid: got %b expected 0", ls_valid); end
      cyc();
      idle();
      #1;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b expected 1", empty); end
      checks++; if (ls_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", ls_valid); end
      a_valid = 1'b1; a_data = 16'h0033;
      cyc();
      a_valid = 1'b0;
      #1;
      checks++; if (ls_data !== 16'h0033 || count !== 3'd1) begin errors++; $display("FAIL flush_refill: got data=%h count=%0d expected 0033/1", ls_data, count); end
      ls_rdy = 1'b1;
      cyc();
      ls_rdy = 1'b0;
   endtask

   task automatic test_back_to_back();
      ls_rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         a_valid = 1'b1; a_data = 16'h0040 + 16'(i);
         cyc();
         checks++;
         if (ls_valid !== 1'b1 || ls_data !== 16'h0040 + 16'(i) || count !== 3'd1) begin
            errors++; $display("FAIL b2b[%0d]: got valid=%b data=%h count=%0d expected 1/%h/1", i, ls_valid, ls_data, count, 16'h0040 + 16'(i));
         end
      end
      a_valid = 1'b0;
      cyc();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_drained: got %b expected 1", empty); end
      ls_rdy = 1'b0;
   endtask

   task automatic test_reset_mid();
      a_valid = 1'b1; a_data = 16'h0061;
      b_valid = 1'b1; b_data = 16'h0062;
      cyc();
      rst = 1'b1; ls_rdy = 1'b1; flush = 1'b0;
      cyc();
      rst = 1'b0;
      idle();
      #1;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", count); end
      checks++; if (ls_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", ls_valid); end
      checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_in_rdy: got %b expected 1", in_rdy); end
   endtask

   task automatic test_bypass();
      a_valid = 1'b1; a_data = 16'h005A; ls_rdy = 1'b1;
      #1;
      checks++; if (ls_valid !== 1'b1 || ls_data !== 16'h005A) begin errors++; $display("FAIL byp_same_cycle: got valid=%b data=%h expected 1/005a", ls_valid, ls_data); end
      cyc();
      a_valid = 1'b0;
      #1;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL byp_not_stored: got %0d expected 0", count); end
      a_valid = 1'b1; a_data = 16'h00C1;
      b_valid = 1'b1; b_data = 16'h00C2;
      #1;
      checks++; if (ls_data !== 16'h00C1) begin errors++; $display("FAIL byp_pair_a: got %h expected 00c1", ls_data); end
      cyc();
      a_valid = 1'b0; b_valid = 1'b0;
      #1;
      checks++; if (count !== 3'd1 || ls_data !== 16'h00C2) begin errors++; $display("FAIL byp_pair_b: got count=%0d data=%h expected 1/00c2", count, ls_data); end
      cyc();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL byp_drained: got %b expected 1", empty); end
      ls_rdy = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
`ifdef LS_ISSUE_BUF_BYPASS_EN
      test_bypass();
`else
      test_single();
      test_pair();
      test_full();
      test_wrap();
      test_flush();
      test_back_to_back();
`endif
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ls_issue_buf.md
LS_ISSUE_BUF -- requirements
Module: ls_issue_buf

Interface
REQ-001 SHALL have parameter Depth, default 4, meaning entry count; power of two, >=2.
REQ-002 SHALL have parameter EntW, default 128, meaning opaque payload width per entry (decoded LS instruction plus operands).
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush_i  input  1  discards all buffered and incoming entries.
REQ-006 SHALL have port a_valid_i  input  1  issue slot A carries an LS instruction.
REQ-007 SHALL have port a_data_i  input  EntW  slot A payload.
REQ-008 SHALL have port b_valid_i  input  1  issue slot B carries an LS instruction.
REQ-009 SHALL have port b_data_i  input  EntW  slot B payload; B is younger than A.
REQ-010 SHALL have port in_rdy_o  output  1  buffer can accept two entries this cycle.
REQ-011 SHALL have port ls_valid_o  output  1  oldest entry presented to the LS pipeline.
REQ-012 SHALL have port ls_data_o  output  EntW  oldest entry payload.
REQ-013 SHALL have port ls_rdy_i  input  1  LS pipeline accepts the presented entry.
REQ-014 SHALL have port count_o  output  $clog2(Depth)+1  registered occupancy.
REQ-015 SHALL have port empty_o  output  1  count_o == 0.

Function
REQ-016 SHALL set in_rdy_o = (Depth - count_o) >= 2, from registered state only, never from ls_rdy_i.
REQ-017 SHALL write when in_rdy_o=1: both valid -> A at wr_ptr, B at wr_ptr+1, wr_ptr += 2; one valid -> that slot at wr_ptr, wr_ptr += 1.
REQ-018 SHALL ignore a_valid_i/b_valid_i when in_rdy_o=0; the issuer holds them.
REQ-019 SHALL pop when ls_valid_o & ls_rdy_i: rd_ptr += 1, count decremented.
REQ-020 SHALL update count by writes minus pop in the same cycle; simultaneous 2-write and pop give net +1.
REQ-021 SHALL wrap pointers modulo Depth; pointers are $clog2(Depth) bits.
REQ-022 SHALL preserve strict program order: A before B, earlier cycles before later.
REQ-023 SHALL keep ls_data_o stable while ls_valid_o=1 and ls_rdy_i=0.
REQ-024 SHALL, on flush_i, next cycle zero count and both pointers, drop same-cycle writes and pops, and hold ls_valid_o=0 in that flush cycle.
REQ-025 SHALL never overflow; count_o never exceeds Depth.
REQ-026 SHALL treat a pop with ls_valid_o=0 as a no-op.

Reset
REQ-027 SHALL, while rst_i is sampled high, clear wr_ptr, rd_ptr and count; rst_i has priority over flush_i and all traffic.
REQ-028 SHALL give after reset: ls_valid_o=0, in_rdy_o=1, count_o=0, empty_o=1, ls_data_o don't-care.
REQ-029 SHALL discard an in-flight entry on reset asserted mid-operation, with no partial pop.

Configuration
REQ-030 SHALL honour macro LS_ISSUE_BUF_BYPASS_EN.
REQ-031 SHALL, with LS_ISSUE_BUF_BYPASS_EN defined and the buffer empty: ls_valid_o = (a_valid_i|b_valid_i) & ~flush_i, and ls_data_o = A payload if a_valid_i else B payload, in the same cycle.
REQ-032 SHALL, on such a bypass with ls_rdy_i=1, not store the bypassed entry; any B behind a bypassed A is stored. Zero-cycle latency.
REQ-033 SHALL, without the macro, drive ls_valid_o = ~empty_o & ~flush_i; minimum latency from write to ls_valid_o is one cycle.

Verification
REQ-034 SHALL cover: reset, then a_valid_i=1 with payload 0x11 -> next cycle ls_valid_o=1, ls_data_o=0x11, count_o=1 (macro off).
REQ-035 SHALL cover: A=0xA1 and B=0xB2 in the same cycle, ls_rdy_i=1 -> pops 0xA1 then 0xB2 on consecutive cycles.
REQ-036 SHALL cover: Depth=4, ls_rdy_i=0, fill to count 3 -> in_rdy_o=0; one pop -> count 2, in_rdy_o=1.
REQ-037 SHALL cover: count 2 plus a 2-write and a pop in the same cycle -> count_o=3, order intact across pointer wrap.
REQ-038 SHALL cover: flush_i with count 3 and a_valid_i=1 -> next cycle count_o=0, empty_o=1, ls_valid_o=0.
REQ-039 SHALL cover: macro on, empty, a_valid_i=1 0x5A, ls_rdy_i=1 -> same cycle ls_valid_o=1 with 0x5A, count_o stays 0.
